// File: rtl/calc_stack_engine_pkg.sv
// Shared types for the RPN calculator stack engine: opcode and FSM state encodings.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SWAP = 3'd6,
    OP_DROP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MUL    = 3'd3,
    ST_PUSHOP = 3'd4
  } state_t;

endpackage

// File: rtl/calc_stack_engine_seq_multiplier.sv
// Signed WIDTH x WIDTH shift-add multiplier. The first partial product is
// taken on the start edge, so done pulses WIDTH cycles after start with the
// full 2*WIDTH product held on the output.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               running;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] src_acc, src_mcand, add_term, nxt_acc;
  logic [WIDTH-1:0]   src_mplier;
  logic [CW-1:0]      src_cnt, nxt_cnt;

  // One shift-add step; the multiplier MSB carries negative weight, so it subtracts.
  always_comb begin
    src_acc    = start ? '0 : acc;
    src_mcand  = start ? {{WIDTH{a[WIDTH-1]}}, a} : mcand;
    src_mplier = start ? b : mplier;
    src_cnt    = start ? '0 : cnt;
    add_term   = src_mplier[0] ? src_mcand : '0;
    nxt_acc    = (src_cnt == CW'(WIDTH - 1)) ? (src_acc - add_term) : (src_acc + add_term);
    nxt_cnt    = src_cnt + CW'(1);
  end

  // Step registers; reset or abort drops any multiply in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      done <= 1'b0;
      if (start || running) begin
        acc     <= nxt_acc;
        mcand   <= src_mcand << 1;
        mplier  <= src_mplier >> 1;
        cnt     <= nxt_cnt;
        running <= (nxt_cnt != CW'(WIDTH));
        done    <= (nxt_cnt == CW'(WIDTH));
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/calc_stack_engine.sv
// RPN calculator engine: decimal entry, DEPTH-deep operand stack, single-cycle
// ALU ops, sequential multiply, sticky error and busy handshake.
module calc_stack_engine
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int MUL_EN = 1
) (
  input  logic                         hwclk,
  input  logic                         reset,
  input  logic                         digit_valid,
  input  logic [3:0]                   digit,
  input  logic                         neg,
  input  logic                         enter,
  input  logic                         op_valid,
  input  logic [2:0]                   opcode,
  input  logic                         clear,
  output logic                         busy,
  output logic [WIDTH-1:0]             top,
  output logic                         sign,
  output logic                         o_flag,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         result_ready
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [DW-1:0]    FULL    = DW'(DEPTH);

  state_t             state, next_state;
  opcode_t            pend_op, exec_op;
  logic [WIDTH-1:0]   stack [0:DEPTH-1];
  logic [WIDTH-1:0]   entry_mag;
  logic               entry_neg;
  logic [WIDTH-1:0]   entry_val, entry_base;
  logic [WIDTH+3:0]   entry_new;
  logic               entry_active;

  logic [IW-1:0]      top_idx, sec_idx, push_idx;
  logic [WIDTH-1:0]   a_val, b_val, sum, diff, alu_res;
  logic               alu_ovf;
  logic               op_err, op_write, op_swap, op_drop, op_mul;
  logic               ev_enter, ev_op, ev_neg, ev_digit, exec_now;
  state_t             exec_next;

  logic               mul_done, mul_ovf, mul_start;
  logic [2*WIDTH-1:0] mul_product;

  assign top_idx    = IW'(depth - DW'(1));
  assign sec_idx    = IW'(depth - DW'(2));
  assign push_idx   = IW'(depth);
  assign a_val      = stack[sec_idx];
  assign b_val      = stack[top_idx];
  assign sum        = a_val + b_val;
  assign diff       = a_val - b_val;
  assign entry_active = (state == ST_ENTRY);
  assign entry_val  = entry_neg ? ('0 - entry_mag) : entry_mag;
  assign entry_base = entry_active ? entry_mag : '0;
  assign entry_new  = ({4'b0, entry_base} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, digit};
  assign mul_ovf    = (mul_product[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_product[WIDTH-1]}});
  assign mul_start  = exec_now && op_mul && !clear;

  // Strobe arbitration: clear beats everything, busy blocks the rest, then enter > op > neg > digit.
  always_comb begin
    ev_enter = !clear && !busy && enter;
    ev_op    = !clear && !busy && !enter && op_valid;
    ev_neg   = !clear && !busy && !enter && !op_valid && neg;
    ev_digit = !clear && !busy && !enter && !op_valid && !neg && digit_valid && (digit <= 4'd9);
    exec_now = (ev_op && !entry_active) || (state == ST_PUSHOP);
    exec_op  = (state == ST_PUSHOP) ? pend_op : opcode_t'(opcode);
  end

  // Operation decode: ALU result, signed overflow and legality against stack depth.
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    op_err   = 1'b0;
    op_write = 1'b0;
    op_swap  = 1'b0;
    op_drop  = 1'b0;
    op_mul   = 1'b0;
    case (exec_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (sum[WIDTH-1] != a_val[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (diff[WIDTH-1] != a_val[WIDTH-1]);
      end
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_XOR:  alu_res = a_val ^ b_val;
      default: alu_res = '0;
    endcase
    case (exec_op)
      OP_SWAP: begin
        op_swap = (depth >= DW'(2));
        op_err  = (depth <  DW'(2));
      end
      OP_DROP: begin
        op_drop = (depth != '0);
        op_err  = (depth == '0);
      end
      OP_MUL: begin
        op_mul  = (MUL_EN != 0) && (depth >= DW'(2));
        op_err  = !((MUL_EN != 0) && (depth >= DW'(2)));
      end
      default: begin
        op_write = (depth >= DW'(2));
        op_err   = (depth <  DW'(2));
      end
    endcase
    exec_next = op_mul ? ST_MUL : (op_err ? ST_IDLE : ST_EXEC);
  end

  // State register.
  always_ff @(posedge hwclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; EXEC is the result pulse cycle and otherwise behaves like IDLE.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_EXEC: begin
          next_state = ST_IDLE;
          if (ev_enter)                next_state = ST_IDLE;
          else if (ev_op)              next_state = exec_next;
          else if (ev_neg || ev_digit) next_state = ST_ENTRY;
        end
        ST_ENTRY: begin
          if (ev_enter)   next_state = ST_IDLE;
          else if (ev_op) next_state = (depth == FULL) ? ST_IDLE : ST_PUSHOP;
        end
        ST_PUSHOP: next_state = exec_next;
        ST_MUL:    next_state = mul_done ? ST_EXEC : ST_MUL;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs: busy during multiply and implicit push, entry value shown while editing.
  always_comb begin
    busy         = (state == ST_MUL) || (state == ST_PUSHOP);
    result_ready = (state == ST_EXEC);
    if (entry_active)      top = entry_val;
    else if (depth != '0)  top = stack[top_idx];
    else                   top = '0;
    sign = top[WIDTH-1];
  end

  // Stack, entry register and flags.
  always_ff @(posedge hwclk) begin
    if (reset || clear) begin
      depth     <= '0;
      entry_mag <= '0;
      entry_neg <= 1'b0;
      o_flag    <= 1'b0;
      err       <= 1'b0;
      pend_op   <= OP_ADD;
    end else if (state == ST_MUL) begin
      if (mul_done) begin
        stack[sec_idx] <= mul_product[WIDTH-1:0];
        depth          <= depth - DW'(1);
        o_flag         <= mul_ovf;
      end
    end else if (ev_enter) begin
      entry_mag <= '0;
      entry_neg <= 1'b0;
      if (entry_active) begin
        if (depth != FULL) begin
          stack[push_idx] <= entry_val;
          depth           <= depth + DW'(1);
        end else begin
          err <= 1'b1;
        end
      end else if ((depth == '0) || (depth == FULL)) begin
        err <= 1'b1;
      end else begin
        stack[push_idx] <= stack[top_idx];
        depth           <= depth + DW'(1);
      end
    end else if (ev_op && entry_active) begin
      pend_op   <= opcode_t'(opcode);
      entry_mag <= '0;
      entry_neg <= 1'b0;
      if (depth != FULL) begin
        stack[push_idx] <= entry_val;
        depth           <= depth + DW'(1);
      end else begin
        err <= 1'b1;
      end
    end else if (exec_now) begin
      if (op_err) err <= 1'b1;
      if (op_write) begin
        stack[sec_idx] <= alu_res;
        depth          <= depth - DW'(1);
        o_flag         <= alu_ovf;
      end
      if (op_swap) begin
        stack[sec_idx] <= b_val;
        stack[top_idx] <= a_val;
      end
      if (op_drop) depth <= depth - DW'(1);
    end else if (ev_neg) begin
      if (entry_active) begin
        entry_neg <= ~entry_neg;
      end else begin
        entry_mag <= '0;
        entry_neg <= 1'b1;
      end
    end else if (ev_digit) begin
      if (entry_new > {4'b0, MAX_POS}) begin
        entry_mag <= entry_base;
        o_flag    <= 1'b1;
      end else begin
        entry_mag <= entry_new[WIDTH-1:0];
        o_flag    <= 1'b0;
      end
      if (!entry_active) entry_neg <= 1'b0;
    end
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (hwclk),
    .reset   (reset),
    .abort   (clear),
    .start   (mul_start),
    .a       (a_val),
    .b       (b_val),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_calc_stack_engine.sv
// Directed testbench for calc_stack_engine (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_calc_stack_engine;

  localparam int K_DIGIT       = 0;
  localparam int K_NEG         = 1;
  localparam int K_ENTER       = 2;
  localparam int K_OP          = 3;
  localparam int K_CLEAR       = 4;
  localparam int K_ENTER_DIGIT = 5;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_SWAP = 6;
  localparam int OP_DROP = 7;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       neg = 1'b0;
  logic       enter = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       clear = 1'b0;
  logic       busy;
  logic [7:0] top;
  logic       sign;
  logic       o_flag;
  logic       err;
  logic [2:0] depth;
  logic       result_ready;

  int checks = 0;
  int errors = 0;

  calc_stack_engine #(.WIDTH(8), .DEPTH(4), .MUL_EN(1)) dut (
    .hwclk        (hwclk),
    .reset        (reset),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .neg          (neg),
    .enter        (enter),
    .op_valid     (op_valid),
    .opcode       (opcode),
    .clear        (clear),
    .busy         (busy),
    .top          (top),
    .sign         (sign),
    .o_flag       (o_flag),
    .err          (err),
    .depth        (depth),
    .result_ready (result_ready)
  );

  // Free-running 100 MHz clock.
  always #5 hwclk = ~hwclk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Holds one strobe for a single cycle; returns #1 after the accepting edge.
  task automatic applyStimulus(input int kind, input int val);
    case (kind)
      K_DIGIT:       begin digit_valid = 1'b1; digit = 4'(val); end
      K_NEG:         neg = 1'b1;
      K_ENTER:       enter = 1'b1;
      K_OP:          begin op_valid = 1'b1; opcode = 3'(val); end
      K_CLEAR:       clear = 1'b1;
      K_ENTER_DIGIT: begin enter = 1'b1; digit_valid = 1'b1; digit = 4'(val); end
      default:       ;
    endcase
    @(posedge hwclk); #1;
    digit_valid = 1'b0;
    neg         = 1'b0;
    enter       = 1'b0;
    op_valid    = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic pushNumber(input int val);
    if (val >= 100) applyStimulus(K_DIGIT, val / 100);
    if (val >= 10)  applyStimulus(K_DIGIT, (val / 10) % 10);
    applyStimulus(K_DIGIT, val % 10);
    applyStimulus(K_ENTER, 0);
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hwclk); #1;
    end
  endtask

  initial begin
    int n;
    int pulses;

    stepCycles(2);
    reset = 1'b0;
    checkOutput("reset_depth", depth, 0);
    checkOutput("reset_top", top, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_oflag", o_flag, 0);
    checkOutput("reset_rr", result_ready, 0);

    // 12 + 30
    applyStimulus(K_DIGIT, 1);
    applyStimulus(K_DIGIT, 2);
    checkOutput("entry_12", top, 12);
    applyStimulus(K_DIGIT, 11);
    checkOutput("digit_ignored", top, 12);
    applyStimulus(K_ENTER, 0);
    checkOutput("push1_depth", depth, 1);
    pushNumber(30);
    checkOutput("push2_depth", depth, 2);
    checkOutput("push2_top", top, 30);
    applyStimulus(K_OP, OP_ADD);
    checkOutput("add_rr", result_ready, 1);
    checkOutput("add_top", top, 42);
    checkOutput("add_depth", depth, 1);
    checkOutput("add_oflag", o_flag, 0);
    stepCycles(1);
    checkOutput("add_rr_off", result_ready, 0);

    // 100 + 50 overflows
    applyStimulus(K_CLEAR, 0);
    checkOutput("clear_depth", depth, 0);
    pushNumber(100);
    pushNumber(50);
    applyStimulus(K_OP, OP_ADD);
    checkOutput("ovf_top", top, 8'h96);
    checkOutput("ovf_sign", sign, 1);
    checkOutput("ovf_oflag", o_flag, 1);

    // -7 * 6
    applyStimulus(K_CLEAR, 0);
    applyStimulus(K_DIGIT, 7);
    applyStimulus(K_NEG, 0);
    checkOutput("neg_entry", top, 8'hF9);
    applyStimulus(K_ENTER, 0);
    pushNumber(6);
    applyStimulus(K_OP, OP_MUL);
    n = 0;
    while (busy && n < 20) begin
      n++;
      stepCycles(1);
    end
    checkOutput("mul_busy_cycles", n, 8);
    checkOutput("mul_rr", result_ready, 1);
    checkOutput("mul_top", top, 8'hD6);
    checkOutput("mul_oflag", o_flag, 0);
    checkOutput("mul_depth", depth, 1);

    // 20 * 10 overflows; enter during busy is ignored
    pushNumber(20);
    pushNumber(10);
    applyStimulus(K_OP, OP_MUL);
    applyStimulus(K_ENTER, 0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      stepCycles(1);
    end
    checkOutput("mul2_busy_cycles", n, 7);
    checkOutput("mul2_top", top, 8'hC8);
    checkOutput("mul2_oflag", o_flag, 1);
    checkOutput("mul2_depth", depth, 2);

    // SWAP, DROP, enter-over-digit priority (duplicate)
    applyStimulus(K_OP, OP_SWAP);
    checkOutput("swap_top", top, 8'hD6);
    checkOutput("swap_rr", result_ready, 1);
    applyStimulus(K_OP, OP_DROP);
    checkOutput("drop_top", top, 8'hC8);
    checkOutput("drop_depth", depth, 1);
    applyStimulus(K_ENTER_DIGIT, 3);
    checkOutput("dup_depth", depth, 2);
    checkOutput("dup_top", top, 8'hC8);

    // Stack overflow, then underflow on SUB
    applyStimulus(K_CLEAR, 0);
    for (int v = 1; v <= 4; v++) pushNumber(v);
    checkOutput("full_depth", depth, 4);
    checkOutput("full_err", err, 0);
    pushNumber(5);
    checkOutput("over_err", err, 1);
    checkOutput("over_depth", depth, 4);
    applyStimulus(K_CLEAR, 0);
    checkOutput("clear_err", err, 0);
    pushNumber(5);
    applyStimulus(K_OP, OP_SUB);
    checkOutput("under_err", err, 1);
    checkOutput("under_depth", depth, 1);
    checkOutput("under_top", top, 5);
    checkOutput("under_rr", result_ready, 0);

    // Entry magnitude limit, then implicit push before ADD
    applyStimulus(K_DIGIT, 1);
    applyStimulus(K_DIGIT, 3);
    checkOutput("entry_13_oflag", o_flag, 0);
    applyStimulus(K_DIGIT, 0);
    checkOutput("entry_130_top", top, 13);
    checkOutput("entry_130_oflag", o_flag, 1);
    applyStimulus(K_OP, OP_ADD);
    checkOutput("pushop_busy", busy, 1);
    checkOutput("pushop_depth", depth, 2);
    checkOutput("pushop_rr", result_ready, 0);
    stepCycles(1);
    checkOutput("implicit_rr", result_ready, 1);
    checkOutput("implicit_top", top, 18);
    checkOutput("implicit_depth", depth, 1);
    checkOutput("implicit_oflag", o_flag, 0);
    checkOutput("err_sticky", err, 1);

    // Reset on the 4th multiply cycle
    applyStimulus(K_CLEAR, 0);
    pushNumber(3);
    pushNumber(4);
    applyStimulus(K_OP, OP_MUL);
    stepCycles(3);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("rst_mul_depth", depth, 0);
    checkOutput("rst_mul_busy", busy, 0);
    checkOutput("rst_mul_top", top, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (result_ready) pulses++;
      stepCycles(1);
    end
    checkOutput("rst_mul_no_rr", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_stack_engine.md
Name: calc_stack_engine

Overview:
- Parametrised successor to the fixed 9-bit two-operand calculator datapath.
- Accepts decimal digit entry, sign toggle, enter and opcode strobes.
- Keeps a DEPTH-deep RPN operand stack of WIDTH-bit two's-complement values and runs ALU ops on the top two entries.
- Adds multi-cycle multiply, stack manipulation, error flags and busy handshaking. Sits between the key/opcode encoders and the seven-segment display path.

Parameters:
WIDTH, 8, operand/result width in bits, two's complement, >=4
DEPTH, 4, stack entries, >=2
MUL_EN, 1, 1 = multiply implemented; 0 = MUL opcode sets err

Ports:
hwclk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
digit_valid  input  1  one-cycle strobe: digit is valid
digit  input  4  decimal digit 0-9; values 10-15 ignored
neg  input  1  strobe: toggle sign of current entry
enter  input  1  strobe: push entry onto stack
op_valid  input  1  strobe: execute opcode
opcode  input  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SWAP, 7 DROP
clear  input  1  strobe: empty stack, clear entry and flags
busy  output  1  engine not accepting strobes
top  output  WIDTH  entry value while editing, else stack top, else 0
sign  output  1  top[WIDTH-1]
o_flag  output  1  arithmetic overflow on last op or entry
err  output  1  sticky stack underflow/overflow or illegal op, cleared by clear/reset
depth  output  $clog2(DEPTH+1)  occupied stack entries
result_ready  output  1  one-cycle pulse when an op result is written

Behaviour:
- Reset (sync, high): stack empty, depth=0, entry inactive, entry value 0, state IDLE. All outputs 0. Reset mid-multiply aborts it; no result is written.
- Strobe priority, same cycle: clear > enter > op_valid > neg > digit_valid. Lower-priority strobes in that cycle are dropped.
- While busy=1, every strobe except clear is ignored, with no flag change.
- States: IDLE, ENTRY, EXEC, MUL, PUSHOP.
- IDLE + digit_valid -> ENTRY, entry = digit. IDLE + neg toggles the sign of an implicit 0 entry and enters ENTRY.
- ENTRY + digit_valid: entry magnitude = mag*10 + digit.
  - If the new magnitude exceeds 2^(WIDTH-1)-1, the digit is dropped and o_flag=1.
  - Otherwise o_flag=0.
- enter with entry active:
  - depth<DEPTH: push entry (negated if the sign toggle is set), then IDLE.
  - depth==DEPTH: discard the entry, set err, then IDLE.
- enter with no entry active: duplicate the top entry. If depth==0 or full, set err.
- op_valid while in ENTRY: implicit push in the first cycle (state PUSHOP, busy=1), then execute. An implicit push that overflows sets err and aborts the op.
- EXEC, one cycle, applies to ADD/SUB/AND/OR/XOR:
  - Requires depth>=2, else err=1 and the stack is unchanged.
  - Operands: a = second entry, b = top. Result is a op b, truncated to WIDTH.
  - The two operands are popped and the result pushed, so depth decreases by 1.
  - o_flag = signed overflow for ADD/SUB; 0 for logic ops.
  - result_ready pulses on the cycle after op_valid is accepted.
- SWAP: exchanges the top two entries (needs depth>=2). DROP: pops one entry (needs depth>=1). Neither touches o_flag. Both pulse result_ready.
- MUL: shift-add over WIDTH cycles with busy=1 throughout.
  - The signed product is truncated to WIDTH.
  - o_flag=1 if the full 2*WIDTH product does not sign-extend from WIDTH bits.
  - Result written and result_ready pulsed WIDTH+1 cycles after acceptance.
  - With MUL_EN=0: err=1, no stack change.
- clear: depth=0, entry inactive, o_flag=0, err=0, top=0. Takes effect next cycle from any state, including MUL.

Decomposition:
- Package calc_pkg: opcode_t enum (8 codes), state_t enum, and the helper constant MAX_POS = 2^(WIDTH-1)-1, computed in the module from WIDTH.
- One sub-module: seq_multiplier, a signed WIDTH x WIDTH shift-add unit.
  - Ports: start/done handshake, 2*WIDTH product output, synchronous abort input.
  - Reusable by later ALU blocks.

Test Plan (WIDTH=8, DEPTH=4):
- Digits 1,2, enter; digits 3,0, enter; op ADD -> next cycle result_ready=1, top=42, depth=1, o_flag=0.
- 100 enter, 50 enter, ADD -> top=0x96 (-106), sign=1, o_flag=1.
- 7, neg, enter; 6, enter; MUL -> busy=1 for 8 cycles, then top=0xD6 (-42), o_flag=0, result_ready on cycle 9.
- Push five values -> fifth sets err=1, depth=4. Then clear, push 1 value, SUB -> err=1, depth=1, top unchanged.
- Digits 1,3,0 -> top=13, o_flag=1 on the third digit. Then op ADD with depth=1 -> implicit push, then depth=2, result 13+prev.
- Reset asserted on the 4th MUL cycle -> next cycle depth=0, busy=0, top=0, and no result_ready pulse.
